// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone constants, slave FSM states and helpers
package wb_pkg;

    localparam int   WB_ADDR_W   = 32;
    localparam logic WB_RTY_TIED = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_sram_array.sv
// rtl/wb_sram_array.sv - byte-enabled backing RAM, one sync read port, one write port
module wb_sram_array #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = DATA_W / 8,
    parameter int AW     = 18
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**AW];
    logic [DATA_W-1:0] rdata_q;

    // No reset: contents survive rst_i so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < SEL_W; k++) begin
            if (we_i && sel_i[k]) begin
                mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone classic slave memory with wait states, RO region and abort
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int                   DATA_W      = 32,
    parameter int                   SEL_W       = DATA_W / 8,
    parameter int                   MEM_AW      = 18,
    parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                   WAIT_STATES = 0,
    parameter int                   RO_WORDS    = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WB_ADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0]    wb_data_i,
    output logic [DATA_W-1:0]    wb_data_o,
    input  logic [SEL_W-1:0]     wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o
);

    localparam int         OFF_W  = clog2(SEL_W);
    localparam int         HI     = MEM_AW + OFF_W;
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    wb_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [MEM_AW-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic              hit, req, ro_in, ro_q, mem_we;
    logic [MEM_AW-1:0] bus_idx, rd_idx;
    logic [DATA_W-1:0] rdata;
    logic              unused_addr_bits;

    assign hit              = (wb_addr_i[WB_ADDR_W-1:HI] == BASE_ADDR[WB_ADDR_W-1:HI]);
    assign bus_idx          = wb_addr_i[HI-1:OFF_W];
    assign req              = wb_cyc_i & wb_stb_i & hit;
    assign unused_addr_bits = ^wb_addr_i[OFF_W-1:0];

    generate
        if (RO_WORDS == 0) begin : g_no_ro
            assign ro_in = 1'b0;
            assign ro_q  = 1'b0;
        end else begin : g_ro
            localparam logic [MEM_AW:0] RO_LIM = (MEM_AW + 1)'(RO_WORDS);
            assign ro_in = wb_we_i & ({1'b0, bus_idx} < RO_LIM);
            assign ro_q  = we_q & ({1'b0, idx_q} < RO_LIM);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d  = bus_idx;
                    we_d   = wb_we_i;
                    sel_d  = wb_sel_i;
                    wdat_d = wb_data_i;
                    cnt_d  = WS_CNT;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                        ack_d   = ~ro_in;
                        err_d   = ro_in;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // A master dropping cyc or stb abandons the transfer outright.
                if (!(wb_cyc_i && wb_stb_i)) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    ack_d   = ~ro_q;
                    err_d   = ro_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // With zero wait states the read must start straight from the bus address.
    assign rd_idx = (state_q == IDLE) ? bus_idx : idx_q;
    assign mem_we = (state_q == RESP) & we_q & ~ro_q & ~rst_i;

    wb_sram_array #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .AW     (MEM_AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .sel_i   (sel_q),
        .waddr_i (idx_q),
        .wdata_i (wdat_q),
        .raddr_i (rd_idx),
        .rdata_o (rdata)
    );

    assign wb_data_o = (ack_q && !we_q) ? rdata : '0;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign wb_rty_o  = WB_RTY_TIED;

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - transaction-level model check of four wb_sram_slave configurations
module tb_wb_sram_slave;

    localparam int          NI = 4;
    localparam int          WS_T   [NI] = '{0, 3, 0, 2};
    localparam int          AW_T   [NI] = '{18, 10, 18, 10};
    localparam int          OFF_T  [NI] = '{2, 2, 2, 3};
    localparam int          RO_T   [NI] = '{0, 16, 0, 0};
    localparam logic [31:0] BASE_T [NI] = '{32'h0, 32'h0, 32'h0010_0000, 32'h0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   addr = '0;
    logic [63:0]   wdata = '0;
    logic [7:0]    sel = '0;
    logic          we = 1'b0;
    logic          stb = 1'b0;
    logic [NI-1:0] cyc = '0;
    logic [NI-1:0] ack, err, rty;
    logic [31:0]   d0, d1, d2;
    logic [63:0]   d3;

    logic [63:0] mm [longint];
    int          exp_cyc  [NI];
    int          exp_kind [NI];
    logic [63:0] exp_dat  [NI];
    longint      exp_key  [NI];
    bit          exp_unk  [NI];
    logic [63:0] got_dat  [NI];
    int          cyc_n = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    wb_sram_slave #(.DATA_W(32), .MEM_AW(18), .BASE_ADDR(32'h0), .WAIT_STATES(0), .RO_WORDS(0)) u0 (
        .clk_i(clk), .rst_i(rst), .wb_addr_i(addr), .wb_data_i(wdata[31:0]), .wb_data_o(d0),
        .wb_sel_i(sel[3:0]), .wb_we_i(we), .wb_cyc_i(cyc[0]), .wb_stb_i(stb),
        .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0]));

    wb_sram_slave #(.DATA_W(32), .MEM_AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(3), .RO_WORDS(16)) u1 (
        .clk_i(clk), .rst_i(rst), .wb_addr_i(addr), .wb_data_i(wdata[31:0]), .wb_data_o(d1),
        .wb_sel_i(sel[3:0]), .wb_we_i(we), .wb_cyc_i(cyc[1]), .wb_stb_i(stb),
        .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1]));

    wb_sram_slave #(.DATA_W(32), .MEM_AW(18), .BASE_ADDR(32'h0010_0000), .WAIT_STATES(0), .RO_WORDS(0)) u2 (
        .clk_i(clk), .rst_i(rst), .wb_addr_i(addr), .wb_data_i(wdata[31:0]), .wb_data_o(d2),
        .wb_sel_i(sel[3:0]), .wb_we_i(we), .wb_cyc_i(cyc[2]), .wb_stb_i(stb),
        .wb_ack_o(ack[2]), .wb_err_o(err[2]), .wb_rty_o(rty[2]));

    wb_sram_slave #(.DATA_W(64), .MEM_AW(10), .BASE_ADDR(32'h0), .WAIT_STATES(2), .RO_WORDS(0)) u3 (
        .clk_i(clk), .rst_i(rst), .wb_addr_i(addr), .wb_data_i(wdata), .wb_data_o(d3),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc[3]), .wb_stb_i(stb),
        .wb_ack_o(ack[3]), .wb_err_o(err[3]), .wb_rty_o(rty[3]));

    function automatic logic [63:0] dout(input int i);
        case (i)
            0:       return {32'h0, d0};
            1:       return {32'h0, d1};
            2:       return {32'h0, d2};
            default: return d3;
        endcase
    endfunction

    // Decode by window arithmetic: kind 0 = no response, 1 = ack, 2 = err.
    function automatic void predict(input int i, input logic [31:0] a, input logic w,
                                    output int kind, output logic [63:0] rd,
                                    output longint key, output bit unk);
        longint span, off, word;
        span = longint'(1) << (AW_T[i] + OFF_T[i]);
        off  = longint'({32'h0, a}) - longint'({32'h0, BASE_T[i]});
        kind = 0;
        rd   = '0;
        key  = 0;
        unk  = 1'b0;
        if (off >= 0 && off < span) begin
            word = off >>> OFF_T[i];
            key  = (longint'(i) << 32) + word;
            if (w && word < longint'(RO_T[i])) begin
                kind = 2;
            end else begin
                kind = 1;
                if (!w) begin
                    if (mm.exists(key)) rd = mm[key];
                    else unk = 1'b1;
                end
            end
        end
    endfunction

    task automatic commit(input int i, input longint key, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] v;
        v = mm.exists(key) ? mm[key] : 64'h0;
        for (int k = 0; k < (1 << OFF_T[i]); k++) begin
            if (s[k]) v[8*k +: 8] = d[8*k +: 8];
        end
        mm[key] = v;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic pin(input string nm, input logic [63:0] model, input logic [63:0] dut, input logic [63:0] lit);
        check({nm, "_model"}, model, lit);
        check({nm, "_dut"}, dut, lit);
    endtask

    // keep: leave the strobe up after the response; chain: slave is in its response cycle now.
    task automatic xfer(input int i, input logic [31:0] a, input logic w, input logic [63:0] d,
                        input logic [7:0] s, input bit keep, input bit chain, output logic [63:0] prd);
        int kind, c0;
        logic [63:0] rd;
        longint key;
        bit unk;
        if (!chain) @(negedge clk);
        predict(i, a, w, kind, rd, key, unk);
        addr = a; we = w; wdata = d; sel = s; stb = 1'b1; cyc[i] = 1'b1;
        c0 = cyc_n + (chain ? 2 : 1) + WS_T[i];
        if (kind != 0) begin
            exp_cyc[i] = c0; exp_kind[i] = kind; exp_dat[i] = rd;
            exp_key[i] = key; exp_unk[i] = unk;
        end
        got_dat[i] = 64'hFEED_FACE_FEED_FACE;
        while (cyc_n < c0) @(negedge clk);
        if (kind == 0) repeat (20) @(negedge clk);
        if (kind == 1 && w) commit(i, key, d, s);
        prd = rd;
        if (!keep) begin
            cyc[i] = 1'b0; stb = 1'b0; we = 1'b0;
            @(negedge clk);
        end
    endtask

    // Start a transfer, then drop stb so the slave sees it low at accept edge + hold + 1.
    task automatic abort_seq(input int i, input logic [31:0] a, input logic w, input logic [63:0] d,
                             input logic [7:0] s, input int hold);
        int n0;
        @(negedge clk);
        addr = a; we = w; wdata = d; sel = s; stb = 1'b1; cyc[i] = 1'b1;
        n0 = cyc_n + 1;
        while (cyc_n < n0 + hold) @(negedge clk);
        stb = 1'b0;
    endtask

    always begin
        logic [66:0] got, want;
        @(posedge clk);
        cyc_n++;
        #1;
        for (int i = 0; i < NI; i++) begin
            got  = {rty[i], ack[i], err[i], dout(i)};
            want = '0;
            if (cyc_n == exp_cyc[i]) begin
                want[65] = (exp_kind[i] == 1);
                want[64] = (exp_kind[i] == 2);
                if (exp_unk[i] && ack[i]) begin
                    mm[exp_key[i]] = dout(i);
                    want[63:0]     = dout(i);
                    exp_unk[i]     = 1'b0;
                end else begin
                    want[63:0] = exp_dat[i];
                end
                if (ack[i]) got_dat[i] = dout(i);
            end
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL cycle_u%0d c=%0d got{rty,ack,err,data}=%h want=%h", i, cyc_n, got, want);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p;
        int n0;
        for (int i = 0; i < NI; i++) begin
            exp_cyc[i] = -1; exp_kind[i] = 0; exp_dat[i] = '0;
            exp_key[i] = 0; exp_unk[i] = 1'b0; got_dat[i] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        xfer(0, 32'h0000_8024, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b1, 1'b0, p);
        xfer(0, 32'h0000_8024, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b1, p);
        pin("t1_read", p, got_dat[0], 64'hDEAD_BEEF);
        xfer(0, 32'h0000_8027, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        pin("t1_offset", p, got_dat[0], 64'hDEAD_BEEF);
        xfer(0, 32'h0000_8028, 1'b1, 64'hAAAA_AAAA, 8'h0F, 1'b0, 1'b0, p);
        xfer(0, 32'h0000_8028, 1'b1, 64'h1122_3344, 8'h05, 1'b0, 1'b0, p);
        xfer(0, 32'h0000_8028, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        pin("t2_lanes", p, got_dat[0], 64'hAA22_AA44);
        xfer(0, 32'h0000_8028, 1'b1, 64'hFFFF_FFFF, 8'h00, 1'b0, 1'b0, p);
        xfer(0, 32'h0000_8028, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        pin("t2_sel0", p, got_dat[0], 64'hAA22_AA44);

        xfer(1, 32'h0000_0100, 1'b1, 64'h0BAD_F00D, 8'h0F, 1'b0, 1'b0, p);
        abort_seq(1, 32'h0000_0100, 1'b0, 64'h0, 8'h0F, 1);
        xfer(1, 32'h0000_0100, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        pin("t3_after_abort", p, got_dat[1], 64'h0BAD_F00D);
        abort_seq(1, 32'h0000_0100, 1'b1, 64'hFFFF_FFFF, 8'h0F, 1);
        xfer(1, 32'h0000_0100, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        pin("t3_abort_write", p, got_dat[1], 64'h0BAD_F00D);

        xfer(1, 32'h0000_0010, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        xfer(1, 32'h0000_0010, 1'b1, 64'h1234_5678, 8'h0F, 1'b0, 1'b0, p);
        xfer(1, 32'h0000_003C, 1'b1, 64'h8765_4321, 8'h0F, 1'b0, 1'b0, p);
        xfer(1, 32'h0000_0010, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        xfer(1, 32'h0000_0040, 1'b1, 64'h5A5A_5A5A, 8'h0F, 1'b0, 1'b0, p);
        xfer(1, 32'h0000_0040, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        pin("t4_word16", p, got_dat[1], 64'h5A5A_5A5A);

        xfer(2, 32'h0000_8000, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        xfer(2, 32'h0020_0000, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        xfer(2, 32'h0010_8000, 1'b1, 64'h600D_CAFE, 8'h0F, 1'b0, 1'b0, p);
        xfer(2, 32'h0010_8000, 1'b0, 64'h0, 8'h0F, 1'b0, 1'b0, p);
        pin("t5_window", p, got_dat[2], 64'h600D_CAFE);

        xfer(3, 32'h0000_0200, 1'b1, 64'h5555_5555_5555_5555, 8'hFF, 1'b0, 1'b0, p);
        xfer(3, 32'h0000_0200, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0, 1'b0, 1'b0, p);
        xfer(3, 32'h0000_0200, 1'b0, 64'h0, 8'hFF, 1'b0, 1'b0, p);
        pin("t6_lanes64", p, got_dat[3], 64'h0123_4567_5555_5555);

        @(negedge clk);
        addr = 32'h0000_0200; we = 1'b1; wdata = '1; sel = 8'hFF; stb = 1'b1; cyc[3] = 1'b1;
        n0 = cyc_n + 1;
        while (cyc_n < n0) @(negedge clk);
        rst = 1'b1; cyc[3] = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        xfer(3, 32'h0000_0200, 1'b0, 64'h0, 8'hFF, 1'b0, 1'b0, p);
        pin("t6_after_reset", p, got_dat[3], 64'h0123_4567_5555_5555);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
